// File: rtl/rob_marker_tracker_if.sv
// Commit-side bundle between the ROB dequeue port and the marker tracker.
// master = ROB/monitor side, slave = tracker.
interface rob_marker_tracker_if #(
    parameter int COMMIT_WIDTH = 2,
    parameter int TAINT_W      = 32,
    parameter int CNT_W        = 16
);
    logic [COMMIT_WIDTH-1:0]    commit_valid;
    logic [32*COMMIT_WIDTH-1:0] commit_inst;
    logic [TAINT_W-1:0]         taint_sum;
    logic [2:0]                 phase;
    logic [CNT_W-1:0]           phase_cycles;
    logic                       marker_valid;
    logic [3:0]                 marker_code;
    logic                       tsx_done;
    logic [TAINT_W-1:0]         leak_taint_max;
    logic                       sim_exit;
    logic                       seq_err;

    modport master (
        output commit_valid, commit_inst, taint_sum,
        input  phase, phase_cycles, marker_valid, marker_code,
               tsx_done, leak_taint_max, sim_exit, seq_err
    );

    modport slave (
        input  commit_valid, commit_inst, taint_sum,
        output phase, phase_cycles, marker_valid, marker_code,
               tsx_done, leak_taint_max, sim_exit, seq_err
    );
endinterface

// File: rtl/rob_marker_tracker.sv
// Phase-marker tracker: scans committed instructions for marker encodings,
// tracks the open fuzzing phase, the tsx window, LEAK peak taint and sim exit.

// Per-lane marker decode (code 15 is not a marker).
module rob_marker_lane_decode (
    input  logic        valid,
    input  logic [31:0] inst,
    output logic        is_marker,
    output logic [3:0]  code
);
    assign code      = inst[23:20];
    assign is_marker = valid && (inst[31:24] == 8'h00) && (inst[19:0] == 20'h02013)
                       && (inst[23:20] != 4'hf);
endmodule

module rob_marker_tracker #(
    parameter int COMMIT_WIDTH = 2,
    parameter int TAINT_W      = 32,
    parameter int CNT_W        = 16,
    parameter int TSX_DELAY    = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    rob_marker_tracker_if.slave   bus
);
    localparam logic [2:0] PH_NONE  = 3'd0;
    localparam logic [2:0] PH_LEAK  = 3'd7;
    localparam logic [3:0] C_EXIT   = 4'd14;
    localparam logic [3:0] C_VCTM_E = 4'd1;
    localparam logic [3:0] C_TEXE_S = 4'd4;

    // Region index (code >> 1) to phase encoding.
    function automatic logic [2:0] region_phase(input logic [2:0] r);
        case (r)
            3'd0:    region_phase = 3'd4;
            3'd1:    region_phase = 3'd5;
            3'd2:    region_phase = 3'd6;
            3'd3:    region_phase = 3'd7;
            3'd4:    region_phase = 3'd1;
            3'd5:    region_phase = 3'd2;
            3'd6:    region_phase = 3'd3;
            default: region_phase = PH_NONE;
        endcase
    endfunction

    logic [COMMIT_WIDTH-1:0][31:0] lane_inst;
    logic [COMMIT_WIDTH-1:0]       lane_mk;
    logic [COMMIT_WIDTH-1:0][3:0]  lane_code;

    assign lane_inst = bus.commit_inst;

    rob_marker_lane_decode u_lane [COMMIT_WIDTH-1:0] (
        .valid     (bus.commit_valid),
        .inst      (lane_inst),
        .is_marker (lane_mk),
        .code      (lane_code)
    );

    logic              exit_latch;
    logic [TSX_DELAY:0] tsx_sr;
    logic [2:0]        nxt_phase;
    logic [2:0]        tgt;
    logic              seq_viol;
    logic              exit_hit;
    logic              tsx_trig;
    logic              mk_valid;
    logic [3:0]        mk_code;

    // Fold lanes oldest to youngest; each marker sees the phase left by the previous one.
    always_comb begin
        nxt_phase = bus.phase;
        tgt       = PH_NONE;
        seq_viol  = 1'b0;
        exit_hit  = 1'b0;
        tsx_trig  = 1'b0;
        mk_valid  = 1'b0;
        mk_code   = 4'd0;
        if (!exit_latch) begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (lane_mk[i] && !exit_hit) begin
                    mk_valid = 1'b1;
                    mk_code  = lane_code[i];
                    if (lane_code[i] == C_EXIT) begin
                        exit_hit = 1'b1;
                    end else begin
                        tgt = region_phase(lane_code[i][3:1]);
                        if (!lane_code[i][0]) begin
                            if (nxt_phase == PH_NONE) nxt_phase = tgt;
                            else                      seq_viol  = 1'b1;
                        end else begin
                            if (nxt_phase == tgt) nxt_phase = PH_NONE;
                            else                  seq_viol  = 1'b1;
                        end
                        if (lane_code[i] == C_VCTM_E || lane_code[i] == C_TEXE_S)
                            tsx_trig = 1'b1;
                    end
                end
            end
        end
    end

    assign bus.tsx_done = tsx_sr[TSX_DELAY];

    // Registered phase state, counters, tsx window, peak taint and exit pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            bus.phase          <= PH_NONE;
            bus.phase_cycles   <= '0;
            bus.marker_valid   <= 1'b0;
            bus.marker_code    <= 4'd0;
            bus.leak_taint_max <= '0;
            bus.sim_exit       <= 1'b0;
            bus.seq_err        <= 1'b0;
            tsx_sr             <= '0;
            exit_latch         <= 1'b0;
        end else begin
            bus.phase <= nxt_phase;
            if (nxt_phase != bus.phase)
                bus.phase_cycles <= '0;
            else if (bus.phase_cycles != {CNT_W{1'b1}})
                bus.phase_cycles <= bus.phase_cycles + 1'b1;
            bus.marker_valid <= mk_valid;
            bus.marker_code  <= mk_code;
            bus.seq_err      <= bus.seq_err | seq_viol;
            // Re-triggers only OR into bit0 so the first trigger sets the timing.
            if (!tsx_sr[TSX_DELAY])
                tsx_sr <= {tsx_sr[TSX_DELAY-1:0], 1'b0} | {{TSX_DELAY{1'b0}}, tsx_trig};
            if (bus.phase == PH_LEAK && bus.taint_sum > bus.leak_taint_max)
                bus.leak_taint_max <= bus.taint_sum;
            bus.sim_exit <= exit_hit;
            if (exit_hit) exit_latch <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rob_marker_tracker.sv
// Randomized + directed bench for rob_marker_tracker with a behavioural model.
module tb_rob_marker_tracker;
    localparam int CW  = 2;
    localparam int TW  = 32;
    localparam int CNW = 5;
    localparam int TD  = 3;
    localparam int PC_MAX = (1 << CNW) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    rob_marker_tracker_if #(.COMMIT_WIDTH(CW), .TAINT_W(TW), .CNT_W(CNW)) bus ();

    rob_marker_tracker #(.COMMIT_WIDTH(CW), .TAINT_W(TW), .CNT_W(CNW), .TSX_DELAY(TD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model state.
    int          m_phase, m_pc, m_code, m_first_trig, m_edge;
    bit          m_mv, m_err, m_exit, m_sim_exit;
    logic [31:0] m_leak;
    // Region -> phase and phase -> region lookup tables.
    int          ph_of_region [7] = '{4, 5, 6, 7, 1, 2, 3};
    int          region_of_ph [8] = '{-1, 4, 5, 6, 0, 1, 2, 3};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int code);
        mk = {8'h00, code[3:0], 20'h02013};
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge(input logic rst, input logic [CW-1:0] v,
                              input logic [31:0] ins [CW], input logic [31:0] taint);
        int  ph, old, code, tgt;
        bit  hit, trig, mv;
        if (!rst) begin
            m_phase = 0; m_pc = 0; m_code = 0; m_mv = 0; m_err = 0; m_exit = 0;
            m_sim_exit = 0; m_leak = 0; m_first_trig = -1; m_edge = 0;
            return;
        end
        old = m_phase; ph = m_phase; hit = 0; trig = 0; mv = 0; code = 0;
        m_code = 0;
        if (!m_exit) begin
            for (int i = 0; i < CW; i++) begin
                if (hit) break;
                if (v[i] && ins[i][31:24] == 0 && ins[i][19:0] == 20'h02013 && ins[i][23:20] != 15) begin
                    code = ins[i][23:20];
                    mv = 1; m_code = code;
                    if (code == 14) hit = 1;
                    else begin
                        tgt = ph_of_region[code / 2];
                        if (code % 2 == 0) begin
                            if (ph == 0) ph = tgt; else m_err = 1;
                        end else begin
                            if (ph == tgt) ph = 0; else m_err = 1;
                        end
                        if (code == 1 || code == 4) trig = 1;
                    end
                end
            end
        end
        if (old == 7 && taint > m_leak) m_leak = taint;
        m_edge++;
        if (trig && m_first_trig < 0) m_first_trig = m_edge;
        m_pc = (ph != old) ? 0 : ((m_pc < PC_MAX) ? m_pc + 1 : PC_MAX);
        m_mv = mv;
        m_sim_exit = hit;
        if (hit) m_exit = 1;
        m_phase = ph;
    endtask

    task automatic compare_all();
        bit exp_tsx;
        exp_tsx = (m_first_trig >= 0) && (m_edge >= m_first_trig + TD);
        chk("phase", bus.phase, m_phase);
        chk("phase_cycles", bus.phase_cycles, m_pc);
        chk("marker_valid", bus.marker_valid, m_mv);
        chk("marker_code", bus.marker_code, m_code);
        chk("tsx_done", bus.tsx_done, exp_tsx);
        chk("leak_taint_max", bus.leak_taint_max, m_leak);
        chk("sim_exit", bus.sim_exit, m_sim_exit);
        chk("seq_err", bus.seq_err, m_err);
    endtask

    // Apply one cycle of stimulus, clock it, update model, then compare.
    task automatic step(input logic rst, input logic [CW-1:0] v,
                        input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] taint);
        logic [31:0] ins [CW];
        ins[0] = i0; ins[1] = i1;
        reset            = rst;
        bus.commit_valid = v;
        bus.commit_inst  = {i1, i0};
        bus.taint_sum    = taint;
        @(posedge clock);
        model_edge(rst, v, ins, taint);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n, input logic [31:0] taint);
        for (int k = 0; k < n; k++) step(1'b1, 2'b00, 32'h0, 32'h0, taint);
    endtask

    initial begin
        int          r;
        int          code;
        logic [31:0] li [CW];
        logic [CW-1:0] lv;
        bus.commit_valid = '0;
        bus.commit_inst  = '0;
        bus.taint_sum    = '0;

        // Reset state.
        step(1'b0, 2'b11, mk(0), mk(6), 32'd5);
        chk("rst_phase", bus.phase, 0);
        chk("rst_pc", bus.phase_cycles, 0);

        // VCTM start/end and tsx window timing.
        step(1'b1, 2'b01, mk(0), 32'h0, 0);
        chk("vctm_open", bus.phase, 4);
        idle(5, 0);
        chk("vctm_pc5", bus.phase_cycles, 5);
        step(1'b1, 2'b01, mk(1), 32'h0, 0);
        chk("vctm_close", bus.phase, 0);
        chk("tsx_early0", bus.tsx_done, 0);
        idle(2, 0);
        chk("tsx_early2", bus.tsx_done, 0);
        idle(1, 0);
        chk("tsx_at3", bus.tsx_done, 1);

        // Start and end of LEAK in the same cycle.
        step(1'b0, 2'b00, 32'h0, 32'h0, 0);
        step(1'b1, 2'b11, mk(6), mk(7), 0);
        chk("same_phase", bus.phase, 0);
        chk("same_code", bus.marker_code, 7);
        chk("same_err", bus.seq_err, 0);

        // Unmatched END, then START.
        step(1'b1, 2'b01, mk(3), 32'h0, 0);
        chk("bad_end_err", bus.seq_err, 1);
        chk("bad_end_phase", bus.phase, 0);
        step(1'b1, 2'b01, mk(2), 32'h0, 0);
        chk("delay_open", bus.phase, 5);

        // LEAK peak taint.
        step(1'b0, 2'b00, 32'h0, 32'h0, 0);
        step(1'b1, 2'b01, mk(6), 32'h0, 32'd100);
        step(1'b1, 2'b00, 32'h0, 32'h0, 32'd3);
        step(1'b1, 2'b00, 32'h0, 32'h0, 32'd9);
        step(1'b1, 2'b00, 32'h0, 32'h0, 32'd4);
        chk("leak_max9", bus.leak_taint_max, 9);
        step(1'b1, 2'b01, mk(7), 32'h0, 32'd0);
        step(1'b1, 2'b00, 32'h0, 32'h0, 32'd50);
        chk("leak_hold9", bus.leak_taint_max, 9);

        // SIM_EXIT with a younger lane, then a later marker.
        step(1'b0, 2'b00, 32'h0, 32'h0, 0);
        step(1'b1, 2'b11, mk(14), mk(8), 0);
        chk("exit_pulse", bus.sim_exit, 1);
        chk("exit_phase", bus.phase, 0);
        idle(1, 0);
        chk("exit_once", bus.sim_exit, 0);
        step(1'b1, 2'b01, mk(8), 32'h0, 0);
        chk("exit_ignore", bus.phase, 0);
        step(1'b1, 2'b01, mk(14), 32'h0, 0);
        chk("exit_no2", bus.sim_exit, 0);

        // Reset mid-run from LEAK, pc=20, tsx_done=1; also saturation.
        step(1'b0, 2'b00, 32'h0, 32'h0, 0);
        step(1'b1, 2'b01, mk(0), 32'h0, 0);
        step(1'b1, 2'b01, mk(1), 32'h0, 0);
        step(1'b1, 2'b01, mk(6), 32'h0, 32'd7);
        idle(20, 32'd7);
        chk("mid_phase", bus.phase, 7);
        chk("mid_pc", bus.phase_cycles, 20);
        chk("mid_tsx", bus.tsx_done, 1);
        idle(20, 32'd7);
        chk("pc_sat", bus.phase_cycles, PC_MAX);
        step(1'b0, 2'b01, mk(7), 32'h0, 0);
        chk("rr_phase", bus.phase, 0);
        chk("rr_tsx", bus.tsx_done, 0);
        chk("rr_leak", bus.leak_taint_max, 0);
        chk("rr_pc", bus.phase_cycles, 0);

        // Randomized stimulus biased toward legal marker sequences.
        for (int n = 0; n < 4000; n++) begin
            int sim_ph;
            sim_ph = m_phase;
            for (int l = 0; l < CW; l++) begin
                r = $urandom_range(0, 19);
                if (r < 5) li[l] = $urandom();
                else if (r < 7) li[l] = {8'h01 << $urandom_range(0, 7), 4'($urandom_range(0, 15)), 20'h02013};
                else if (r < 17) begin
                    if (sim_ph == 0) code = 2 * $urandom_range(0, 6);
                    else             code = 2 * region_of_ph[sim_ph] + 1;
                    li[l] = mk(code);
                    sim_ph = (code % 2 == 0) ? ph_of_region[code / 2] : 0;
                end
                else if (r < 19) li[l] = mk($urandom_range(0, 13));
                else             li[l] = mk($urandom_range(14, 15));
                lv[l] = ($urandom_range(0, 3) != 0);
            end
            step(($urandom_range(0, 59) != 0), lv, li[0], li[1],
                 ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 200)) : $urandom());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rob_marker_tracker.md
Name: rob_marker_tracker

Overview:
- Synthesizable stage between the ROB commit (dequeue) port and the simulation sync monitor.
- Each cycle it scans the committed instructions for phase-marker encodings and tracks which fuzzing phase is currently open (INIT, BIM, TRAIN, VCTM, DELAY, TEXE, LEAK).
- Produces registered phase state, a per-phase cycle counter, the transaction-done window, the peak taint seen during LEAK, and a sim-exit pulse.
- Instantiated once per core copy (DUT and variant).

Parameters:
COMMIT_WIDTH, 2, number of ROB commit lanes scanned per cycle
TAINT_W, 32, width of taint_sum input
CNT_W, 16, width of phase_cycles counter
TSX_DELAY, 3, cycles from tsx trigger to tsx_done assertion (1..8)

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-low
commit_valid  in  COMMIT_WIDTH  per-lane commit valid, lane 0 oldest
commit_inst  in  32*COMMIT_WIDTH  per-lane instruction, lane i at bits [32i+31:32i]
taint_sum  in  TAINT_W  current core taint sum
phase  out  3  open phase: 0 NONE, 1 INIT, 2 BIM, 3 TRAIN, 4 VCTM, 5 DELAY, 6 TEXE, 7 LEAK
phase_cycles  out  CNT_W  cycles spent in current phase, saturating
marker_valid  out  1  at least one marker committed last cycle
marker_code  out  4  code of youngest marker committed last cycle
tsx_done  out  1  sticky transaction-done flag
leak_taint_max  out  TAINT_W  max taint_sum sampled while phase==LEAK
sim_exit  out  1  one-cycle pulse on SIM_EXIT marker
seq_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (reset==0 at posedge): all outputs 0; phase=NONE; tsx shift register cleared; exit latch cleared. Reset wins over any same-cycle commit.
- Marker decode: lane is a marker iff valid, inst[31:24]==0, inst[19:0]==20'h02013.
  - code=inst[23:20].
  - Even code 2k is START of region k; odd code 2k+1 is END of region k.
  - Region k maps to phase: 0 VCTM(4), 1 DELAY(5), 2 TEXE(6), 3 LEAK(7), 4 INIT(1), 5 BIM(2), 6 TRAIN(3).
  - Code 14 is SIM_EXIT; code 15 is not a marker.
- Lanes are folded in order 0..COMMIT_WIDTH-1 within one cycle; each marker acts on the phase produced by the previous lane.
- Phase FSM, per marker:
  - START of X with phase NONE: phase becomes X.
  - END of X with phase X: phase becomes NONE.
  - Any other START/END: seq_err<=1, phase unchanged.
- All outputs are registered; a marker committed in cycle n is reflected in cycle n+1.
- phase_cycles:
  - Loads 0 on the cycle phase changes.
  - Otherwise increments by 1 per cycle, saturating at 2^CNT_W-1.
  - Counts in NONE too.
- marker_valid/marker_code: registered from the highest-index marker lane; 0/0 when no marker.
- tsx window:
  - Trigger is VCTM_END (code 1) or TEXE_START (code 4) in any lane.
  - A trigger sets bit0 of a TSX_DELAY+1 bit shift register, which shifts left every cycle while tsx_done==0.
  - tsx_done=1 when bit TSX_DELAY is set, and stays 1 until reset.
  - Re-triggers while shifting OR into bit0; they do not restart the count.
- leak_taint_max:
  - Each cycle the registered phase==LEAK, it updates to max(leak_taint_max, taint_sum) (unsigned).
  - Otherwise it holds.
  - Not cleared on a new LEAK region.
- SIM_EXIT:
  - sim_exit pulses 1 for exactly one cycle and sets the internal exit latch.
  - Lanes younger than the SIM_EXIT lane in that cycle are ignored.
  - Once latched, all later markers are ignored, and phase/counters freeze except phase_cycles, which keeps counting.
  - A second SIM_EXIT produces no pulse.

Test Plan:
- Reset mid-run: phase=LEAK, phase_cycles=20, tsx_done=1; drive reset=0 for one cycle → next cycle all outputs 0, phase=NONE.
- Lane 0 inst 32'h00002013 (VCTM_START), then 5 idle cycles, then 32'h00102013 (VCTM_END) → phase=4 one cycle after START; phase_cycles reaches 5; phase=0 one cycle after END; tsx_done=1 exactly TSX_DELAY=3 cycles after phase returns to 0.
- Same cycle: lane 0 32'h00602013 (LEAK_START), lane 1 32'h00702013 (LEAK_END) → next cycle phase=0, marker_code=7, seq_err=0.
- phase NONE, commit 32'h00302013 (DELAY_END) → seq_err=1, phase stays 0; then DELAY_START → phase=5.
- LEAK open, taint_sum sequence 3, 9, 4 → leak_taint_max=9; after LEAK_END, taint_sum=50 → leak_taint_max stays 9.
- Lane 0 32'h00e02013 (SIM_EXIT), lane 1 32'h00802013 (INIT_START) → sim_exit=1 for one cycle; phase stays 0; a later INIT_START has no effect.
